// File: rtl/token_window_counter_pkg.sv
// Shared widths and default parameters for the token window counter and its neighbours.
package token_pkg;

  localparam int unsigned WINDOW_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 2;

  // Width needed to hold a count of 0..window tokens.
  function automatic int unsigned cnt_w(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/token_window_counter_if.sv
// Result stream of the token window counter: valid/ready with a window count payload.
interface token_window_counter_if #(
  parameter int unsigned CW = 4
) ();

  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_count;

  modport master (output out_valid, output out_count, input out_ready);
  modport slave  (input out_valid, input out_count, output out_ready);

endinterface

// File: rtl/token_window_counter_fifo.sv
// Circular synchronous buffer: pointer wrap and occupancy count only.
module token_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNTW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CNTW'(DEPTH));
  assign dout   = r_mem[r_rd_ptr];
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/token_window_counter.sv
// Counts '1' tokens over back-to-back windows of WINDOW cycles and queues each count;
// a count that finds the queue full is discarded and flagged with a one-cycle drop pulse.
module token_window_counter
  import token_pkg::*;
#(
  parameter int unsigned WINDOW = WINDOW_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          a,
  token_window_counter_if.master        out_if,
  output logic                          drop
);

  localparam int unsigned CW   = cnt_w(WINDOW);
  localparam int unsigned PH_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  logic [PH_W-1:0] r_ph;
  logic [CW-1:0]   r_acc;
  logic            r_drop;
  logic            w_end;
  logic [CW-1:0]   w_result;
  logic            w_pop;
  logic            w_push;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_dout;

  assign w_end    = (r_ph == PH_W'(WINDOW - 1));
  assign w_result = r_acc + CW'(a);
  assign w_pop    = ~w_empty & out_if.out_ready;
  assign w_push   = w_end & (~w_full | w_pop);

  // Phase counter free-runs; accumulator restarts at phase 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph   <= '0;
      r_acc  <= '0;
      r_drop <= 1'b0;
    end else begin
      r_ph   <= w_end ? '0 : r_ph + PH_W'(1);
      r_acc  <= (r_ph == '0) ? CW'(a) : w_result;
      r_drop <= w_end & w_full & ~w_pop;
    end
  end

  token_fifo #(
    .WIDTH (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_result),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full)
  );

  assign out_if.out_valid = ~w_empty;
  assign out_if.out_count = w_empty ? '0 : w_dout;
  assign drop             = r_drop;

endmodule

// File: tb/tb_token_window_counter.sv
// Scoreboard bench for token_window_counter: directed cycle checks at WINDOW=4/8 and random sweeps at 2/5/8.
module tb_token_window_counter;
  import token_pkg::*;

  localparam int DEPTH = 2;
  localparam int LOG_N = 32;

  logic       clk = 1'b0;
  logic       a_v     [4];
  logic       rdy_v   [4];
  logic       rst_v   [4];
  logic       valid_v [4];
  logic [3:0] cnt_v   [4];
  logic       drop_v  [4];

  always #5 clk = ~clk;

  token_window_counter_if #(.CW(cnt_w(4))) if4 ();
  token_window_counter_if #(.CW(cnt_w(2))) if2 ();
  token_window_counter_if #(.CW(cnt_w(5))) if5 ();
  token_window_counter_if #(.CW(cnt_w(8))) if8 ();

  token_window_counter #(.WINDOW(4), .DEPTH(DEPTH)) u_w4 (
    .clk(clk), .rst(rst_v[0]), .a(a_v[0]), .out_if(if4), .drop(drop_v[0]));
  token_window_counter #(.WINDOW(2), .DEPTH(DEPTH)) u_w2 (
    .clk(clk), .rst(rst_v[1]), .a(a_v[1]), .out_if(if2), .drop(drop_v[1]));
  token_window_counter #(.WINDOW(5), .DEPTH(DEPTH)) u_w5 (
    .clk(clk), .rst(rst_v[2]), .a(a_v[2]), .out_if(if5), .drop(drop_v[2]));
  token_window_counter #(.WINDOW(8), .DEPTH(DEPTH)) u_w8 (
    .clk(clk), .rst(rst_v[3]), .a(a_v[3]), .out_if(if8), .drop(drop_v[3]));

  assign if4.out_ready = rdy_v[0];
  assign if2.out_ready = rdy_v[1];
  assign if5.out_ready = rdy_v[2];
  assign if8.out_ready = rdy_v[3];
  assign valid_v[0] = if4.out_valid;
  assign valid_v[1] = if2.out_valid;
  assign valid_v[2] = if5.out_valid;
  assign valid_v[3] = if8.out_valid;
  assign cnt_v[0] = 4'(if4.out_count);
  assign cnt_v[1] = 4'(if2.out_count);
  assign cnt_v[2] = 4'(if5.out_count);
  assign cnt_v[3] = 4'(if8.out_count);

  int n_chk  = 0;
  int n_pass = 0;

  // Scoreboard: expected buffer contents, plus the reference window state.
  int q[$];
  int sel, m_w, m_ph, m_acc, m_drop;
  int log_v [LOG_N];
  int log_c [LOG_N];
  int log_d [LOG_N];

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s (W=%0d): got %0d, expected %0d at %0t", tag, m_w, obs, exp, $time);
  endtask

  task automatic start(input int s, input int w);
    sel = s; m_w = w;
    q.delete(); m_ph = 0; m_acc = 0; m_drop = 0;
    for (int i = 0; i < LOG_N; i++) begin log_v[i] = -1; log_c[i] = -1; log_d[i] = -1; end
    a_v[s] = 1'b0; rdy_v[s] = 1'b0; rst_v[s] = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic finish_run();
    rst_v[sel] = 1'b1; rdy_v[sel] = 1'b0; a_v[sel] = 1'b0;
  endtask

  // One cycle: compare outputs of cycle t, drive its inputs, advance the model.
  task automatic run_cycle(input int t, input logic ia, input logic irdy, input logic irst);
    logic ov, od, pop, wend;
    logic [3:0] oc;
    int sz, popped;
    @(negedge clk);
    ov = valid_v[sel]; oc = cnt_v[sel]; od = drop_v[sel];
    if (t >= 0 && t < LOG_N) begin log_v[t] = int'(ov); log_c[t] = int'(oc); log_d[t] = int'(od); end
    check("out_valid", int'(ov), (q.size() != 0) ? 1 : 0);
    check("drop", int'(od), m_drop);
    if (q.size() != 0) check("out_count", int'(oc), q[0]);
    else check("out_count_zero", int'(oc), 0);
    a_v[sel] = ia; rdy_v[sel] = irdy; rst_v[sel] = irst;
    sz  = q.size();
    pop = (sz != 0) && irdy;
    if (pop) popped = q.pop_front();
    if (irst) begin
      q.delete(); m_ph = 0; m_acc = 0; m_drop = 0;
    end else begin
      m_acc  = (m_ph == 0) ? int'(ia) : m_acc + int'(ia);
      wend   = (m_ph == m_w - 1);
      m_drop = 0;
      if (wend) begin
        if (sz < DEPTH || pop) q.push_back(m_acc);
        else m_drop = 1;
      end
      m_ph = wend ? 0 : m_ph + 1;
    end
  endtask

  initial begin
    logic [11:0] pat12;
    logic [7:0]  pat8;
    logic [15:0] pat16;
    int dsum;
    for (int i = 0; i < 4; i++) begin a_v[i] = 1'b0; rdy_v[i] = 1'b0; rst_v[i] = 1'b1; end
    repeat (3) @(negedge clk);

    // Basic stream with the consumer always ready.
    start(0, 4);
    pat12 = 12'b1101_0000_1111;
    for (int t = 0; t < 16; t++) run_cycle(t, (t < 12) ? pat12[11 - t] : 1'b0, 1'b1, 1'b0);
    check("basic_v4", log_v[4], 1);  check("basic_c4", log_c[4], 3);
    check("basic_v5", log_v[5], 0);  check("basic_v8", log_v[8], 1);
    check("basic_c8", log_c[8], 0);  check("basic_v12", log_v[12], 1);
    check("basic_c12", log_c[12], 4);
    dsum = 0;
    for (int t = 0; t < 16; t++) dsum += log_d[t];
    check("basic_no_drop", dsum, 0);
    finish_run();

    // Backpressure until the third window is dropped, then drain.
    start(0, 4);
    for (int t = 0; t < 18; t++) run_cycle(t, (t < 12) ? 1'b1 : 1'b0, (t >= 13) ? 1'b1 : 1'b0, 1'b0);
    check("bp_drop11", log_d[11], 0); check("bp_drop12", log_d[12], 1);
    check("bp_drop13", log_d[13], 0); check("bp_v13", log_v[13], 1);
    check("bp_c13", log_c[13], 4);    check("bp_c14", log_c[14], 4);
    check("bp_v15", log_v[15], 0);
    finish_run();

    // Pop coincides with the window end while full: push accepted, order kept.
    start(0, 4);
    pat16 = 16'b1000_1100_1110_0000;
    for (int t = 0; t < 20; t++)
      run_cycle(t, pat16[15 - t], (t == 11 || t >= 14) ? 1'b1 : 1'b0, 1'b0);
    check("sim_drop12", log_d[12], 0); check("sim_v12", log_v[12], 1);
    check("sim_c12", log_c[12], 2);    check("sim_c13", log_c[13], 2);
    check("sim_c14", log_c[14], 2);    check("sim_c15", log_c[15], 3);
    check("sim_v16", log_v[16], 1);    check("sim_c16", log_c[16], 0);
    finish_run();

    // Reset mid-window discards the partial window silently.
    start(0, 4);
    for (int t = 0; t < 14; t++) run_cycle(t, 1'b1, 1'b1, (t == 6) ? 1'b1 : 1'b0);
    check("rst_c4", log_c[4], 4);
    for (int t = 7; t < 11; t++) check("rst_quiet", log_v[t], 0);
    check("rst_v11", log_v[11], 1); check("rst_c11", log_c[11], 4);
    check("rst_d7", log_d[7], 0);
    finish_run();

    // Halved stream over a full 8-cycle window.
    start(3, 8);
    pat8 = 8'b0101_0101;
    for (int t = 0; t < 12; t++) run_cycle(t, (t < 8) ? pat8[7 - t] : 1'b0, 1'b1, 1'b0);
    check("half_v7", log_v[7], 0); check("half_v8", log_v[8], 1);
    check("half_c8", log_c[8], 4); check("half_v9", log_v[9], 0);
    finish_run();

    // Random sweep over several window lengths, with occasional resets.
    for (int s = 1; s < 4; s++) begin
      start(s, (s == 1) ? 2 : (s == 2) ? 5 : 8);
      for (int t = 0; t < 400; t++)
        run_cycle(t, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
      finish_run();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/token_window_counter.md
# token_window_counter

Downstream consumer of the serial token stream produced by the token-halving stage. Counts '1' tokens over fixed, back-to-back windows of `WINDOW` cycles. Pushes each window's count into a small buffer, which is drained through a valid/ready interface. When the buffer is full at a window boundary, that window's result is dropped and flagged.

## Interface
- `WINDOW`, default 8: window length in clock cycles; legal range ≥ 2.
- `DEPTH`, default 2: result buffer entries; must be a power of two, ≥ 2.
- `clk`  input  1  clock; all logic on its rising edge.
- `rst`  input  1  reset; synchronous and active-high.
- `a`  input  1  serial token stream; 1 = token present this cycle.
- `out_valid`  output  1  buffer head holds a result.
- `out_ready`  input  1  consumer accepts head this cycle.
- `out_count`  output  CW  head window count; CW = $clog2(WINDOW+1).
- `drop`  output  1  one-cycle pulse: a window result was discarded.

## Operation
- Window phase counter `ph` runs 0..WINDOW-1 and wraps. It free-runs and is not gated by `out_ready`.
- Token accumulator `acc` (CW bits):
  - When `ph` = 0: `acc` loads `a`.
  - Otherwise: `acc` adds `a`.
  - `acc` never saturates; max value = WINDOW.
- Window end is the cycle where `ph` = WINDOW-1. Result = `acc` + `a` of that cycle.
  - If the buffer is not full, or a pop occurs in the same cycle: push the result.
  - Else: discard the result and assert `drop` in the following cycle.
- Pop: `out_valid` & `out_ready` removes the head.
  - `out_ready` while `out_valid` = 0 has no effect.
- Buffer is a first-in, first-out circular buffer with read/write pointers and a count of log2(DEPTH)+1 bits.
  - Full when count = DEPTH.
  - Push and pop in the same cycle leave the count unchanged, including when full or when holding 1 entry.
- `out_count` is the head entry when `out_valid` = 1, and is driven to 0 when `out_valid` = 0.
- Reset clears `ph`, `acc`, pointers, count and `drop`.
  - Outputs in reset and in the first cycle after reset: `out_valid`=0, `out_count`=0, `drop`=0.
  - A partial window at reset is discarded without a drop pulse.
  - The first window starts in the first cycle with `rst` = 0.

## Timing
- Cycle 0 is the first cycle with `rst` low.
- Window k covers cycles k·WINDOW .. k·WINDOW+WINDOW-1.
- Result latency: the result is visible (`out_valid`=1, if the buffer was empty) in cycle (k+1)·WINDOW, one cycle after the window end.
- `drop` is asserted in cycle (k+1)·WINDOW for exactly one cycle.
- Pop takes effect at the clock edge. The next entry is presented in the following cycle; there is no bubble when more entries are queued.
- Sustained throughput: one result per WINDOW cycles, with no drops when `out_ready` is held high.
- No combinational path from `a` to any output. `out_ready` affects outputs only through registers.

## Structure
- Package `token_pkg` holds:
  - the function `cnt_w(int window)` returning $clog2(window+1);
  - the localparam defaults WINDOW_DEF=8 and DEPTH_DEF=2, shared with the token-halving stage bench.
- Sub-module `token_fifo`: parameterised width/depth synchronous buffer with `push`, `pop`, `din`, `dout`, `empty`, `full`. It contains pointer wrap and count logic only.
- Top level contains the phase counter, accumulator, push/drop decision and the `out_count` zero-masking.

## Test plan
All scenarios use WINDOW=4, DEPTH=2 unless stated.
- Basic: `out_ready`=1, `a` = 1101_0000_1111 from cycle 0 → `out_valid` pulses in cycles 4, 8, 12 with `out_count` = 3, 0, 4; `drop` is never asserted.
- Backpressure/full: `out_ready`=0, `a`=1 for cycles 0–11 →
  - results 4, 4 are buffered;
  - `drop`=1 only in cycle 12;
  - then `out_ready`=1 in cycle 13 → `out_count` 4 in cycle 13 and 4 in cycle 14, then `out_valid`=0.
- Simultaneous push/pop when full: buffer holds 2 entries, `out_ready`=1 only in cycle 11 (window end) → no `drop`; count stays 2; order is preserved.
- Reset mid-window: `a`=1, `rst` pulsed in cycle 6 → no output for the partial window; the first result (4) appears 4 cycles after `rst` deasserts.
- Full window from the halving stage: feed `a` = 0101_0101 (halved 1111_1111) with WINDOW=8 → single `out_count`=4 in cycle 8.
- Randomised sweep over WINDOW ∈ {2, 5, 8} with random `a` and `out_ready` → scoreboard matches popped values in order, plus each `drop` against a reference model.
